// File: rtl/fpro_bus_arbiter.sv
// Two-requester FPro bus arbiter: round-robin with bounded ownership, registered bus, tagged read return.
// Optional macro FPRO_ARB_FIXED_PRIO_EN gives m1 absolute priority (MAX_HOLD then limits m0 only).
module fpro_bus_arbiter #(
    parameter int ADDR_W   = 21,
    parameter int DATA_W   = 32,
    parameter int RD_LAT   = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic              m0_rd,
    input  logic              m0_mmio_cs,
    input  logic              m0_video_cs,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wr_data,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rd_data,
    output logic              m0_rd_valid,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic              m1_rd,
    input  logic              m1_mmio_cs,
    input  logic              m1_video_cs,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wr_data,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rd_data,
    output logic              m1_rd_valid,
    input  logic [DATA_W-1:0] fp_rd_data,
    output logic [ADDR_W-1:0] fp_addr,
    output logic [DATA_W-1:0] fp_wr_data,
    output logic              fp_wr,
    output logic              fp_rd,
    output logic              fp_mmio_cs,
    output logic              fp_video_cs,
    output logic [1:0]        owner
);

    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

    typedef struct packed {
        logic              wr;
        logic              rd;
        logic              mmio_cs;
        logic              video_cs;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wr_data;
    } cmd_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       last, last_nxt;   // requester served most recently (0=m0, 1=m1)
    logic       pick1;
    logic       acc;
    logic       rd_push;
    cmd_t       cmd0, cmd1, cmd;
    logic [RD_LAT:0] trk_vld, trk_id;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 8'd0;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            last  <= last_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        last_nxt  = last;
        pick1     = 1'b0;
        case (state)
            IDLE: begin
`ifdef FPRO_ARB_FIXED_PRIO_EN
                pick1 = m1_req;
`else
                pick1 = m1_req && (!m0_req || !last);
`endif
                if (m0_req || m1_req) begin
                    state_nxt = pick1 ? OWN1 : OWN0;
                    last_nxt  = pick1;
                    cnt_nxt   = 8'd0;
                end
            end
            OWN0: begin
                if (!m0_req) begin
                    cnt_nxt   = 8'd0;
                    state_nxt = m1_req ? OWN1 : IDLE;
                    if (m1_req) last_nxt = 1'b1;
                end else if (m1_req && cnt == HOLD_LAST) begin
                    state_nxt = OWN1;
                    cnt_nxt   = 8'd0;
                    last_nxt  = 1'b1;
                end else if (cnt != HOLD_LAST) begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            OWN1: begin
                if (!m1_req) begin
                    cnt_nxt   = 8'd0;
                    state_nxt = m0_req ? OWN0 : IDLE;
                    if (m0_req) last_nxt = 1'b0;
`ifndef FPRO_ARB_FIXED_PRIO_EN
                end else if (m0_req && cnt == HOLD_LAST) begin
                    state_nxt = OWN0;
                    cnt_nxt   = 8'd0;
                    last_nxt  = 1'b0;
`endif
                end else if (cnt != HOLD_LAST) begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        m0_ack = (state == OWN0) && m0_req;
        m1_ack = (state == OWN1) && m1_req;
        owner  = state;
    end

    assign cmd0    = '{m0_wr, m0_rd, m0_mmio_cs, m0_video_cs, m0_addr, m0_wr_data};
    assign cmd1    = '{m1_wr, m1_rd, m1_mmio_cs, m1_video_cs, m1_addr, m1_wr_data};
    assign cmd     = m1_ack ? cmd1 : cmd0;
    assign acc     = m0_ack || m1_ack;
    // A combined wr+rd command is issued as a write only.
    assign rd_push = acc && cmd.rd && !cmd.wr;

    always_ff @(posedge clk) begin
        if (reset) begin
            fp_addr     <= '0;
            fp_wr_data  <= '0;
            fp_wr       <= 1'b0;
            fp_rd       <= 1'b0;
            fp_mmio_cs  <= 1'b0;
            fp_video_cs <= 1'b0;
        end else begin
            fp_wr       <= acc && cmd.wr;
            fp_rd       <= rd_push;
            fp_mmio_cs  <= acc && cmd.mmio_cs;
            fp_video_cs <= acc && cmd.video_cs;
            if (acc) begin
                fp_addr    <= cmd.addr;
                fp_wr_data <= cmd.wr_data;
            end
        end
    end

    // Stage k holds reads accepted k+1 cycles ago; stage RD_LAT lines up with returning data.
    always_ff @(posedge clk) begin
        if (reset) begin
            trk_vld <= '0;
            trk_id  <= '0;
        end else begin
            trk_vld <= {trk_vld[RD_LAT-1:0], rd_push};
            trk_id  <= {trk_id[RD_LAT-1:0], m1_ack};
        end
    end

    assign m0_rd_data  = fp_rd_data;
    assign m1_rd_data  = fp_rd_data;
    assign m0_rd_valid = trk_vld[RD_LAT] && !trk_id[RD_LAT];
    assign m1_rd_valid = trk_vld[RD_LAT] &&  trk_id[RD_LAT];

endmodule

// File: tb/tb_fpro_bus_arbiter.sv
// Directed bench for fpro_bus_arbiter (RD_LAT=1, MAX_HOLD=8), one step per clock cycle.
module tb_fpro_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_wr, m0_rd, m0_mmio_cs, m0_video_cs;
    logic [20:0] m0_addr;
    logic [31:0] m0_wr_data;
    logic        m0_ack, m0_rd_valid;
    logic [31:0] m0_rd_data;
    logic        m1_req, m1_wr, m1_rd, m1_mmio_cs, m1_video_cs;
    logic [20:0] m1_addr;
    logic [31:0] m1_wr_data;
    logic        m1_ack, m1_rd_valid;
    logic [31:0] m1_rd_data;
    logic [31:0] fp_rd_data;
    logic [20:0] fp_addr;
    logic [31:0] fp_wr_data;
    logic        fp_wr, fp_rd, fp_mmio_cs, fp_video_cs;
    logic [1:0]  owner;

    int n_chk  = 0;
    int n_fail = 0;

    fpro_bus_arbiter #(.ADDR_W(21), .DATA_W(32), .RD_LAT(1), .MAX_HOLD(8)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_rd(m0_rd), .m0_mmio_cs(m0_mmio_cs),
        .m0_video_cs(m0_video_cs), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
        .m0_ack(m0_ack), .m0_rd_data(m0_rd_data), .m0_rd_valid(m0_rd_valid),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_rd(m1_rd), .m1_mmio_cs(m1_mmio_cs),
        .m1_video_cs(m1_video_cs), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
        .m1_ack(m1_ack), .m1_rd_data(m1_rd_data), .m1_rd_valid(m1_rd_valid),
        .fp_rd_data(fp_rd_data), .fp_addr(fp_addr), .fp_wr_data(fp_wr_data),
        .fp_wr(fp_wr), .fp_rd(fp_rd), .fp_mmio_cs(fp_mmio_cs), .fp_video_cs(fp_video_cs),
        .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        {m0_req, m0_wr, m0_rd, m0_mmio_cs, m0_video_cs} = '0;
        {m1_req, m1_wr, m1_rd, m1_mmio_cs, m1_video_cs} = '0;
        m0_addr = '0; m0_wr_data = '0; m1_addr = '0; m1_wr_data = '0;
        fp_rd_data = '0;
        tick(); tick();
        chk("rst_owner", owner, 0);
        chk("rst_fp_wr", fp_wr, 0);
        chk("rst_fp_rd", fp_rd, 0);
        chk("rst_fp_addr", fp_addr, 0);
        chk("rst_ack0", m0_ack, 0);
        reset = 1'b0;

        // single m0 write
        tick();
        m0_req = 1; m0_wr = 1; m0_mmio_cs = 1; m0_addr = 21'h10; m0_wr_data = 32'hDEADBEEF;
        #1 chk("w_idle_ack0", m0_ack, 0);
        tick();
        chk("w_ack0", m0_ack, 1);
        chk("w_ack1", m1_ack, 0);
        chk("w_owner", owner, 1);
        tick();
        chk("w_fp_wr", fp_wr, 1);
        chk("w_fp_rd", fp_rd, 0);
        chk("w_fp_addr", fp_addr, 32'h10);
        chk("w_fp_data", fp_wr_data, 32'hDEADBEEF);
        chk("w_fp_mmio", fp_mmio_cs, 1);
        m0_req = 0; m0_wr = 0; m0_mmio_cs = 0;
        #1 chk("w_ack0_drop", m0_ack, 0);
        tick();
        chk("w_fp_wr_off", fp_wr, 0);
        chk("w_fp_addr_hold", fp_addr, 32'h10);
        chk("w_owner_idle", owner, 0);

        // single m0 read, data returns two cycles after ack
        m0_req = 1; m0_rd = 1; m0_addr = 21'h20; fp_rd_data = 32'h12345678;
        tick();
        chk("r_ack0", m0_ack, 1);
        tick();
        m0_req = 0; m0_rd = 0;
        chk("r_fp_rd", fp_rd, 1);
        chk("r_fp_wr", fp_wr, 0);
        chk("r_early_valid", m0_rd_valid, 0);
        tick();
        chk("r_valid0", m0_rd_valid, 1);
        chk("r_data0", m0_rd_data, 32'h12345678);
        chk("r_valid1", m1_rd_valid, 0);
        chk("r_fp_rd_off", fp_rd, 0);
        tick();
        chk("r_valid0_off", m0_rd_valid, 0);

        // combined wr+rd: write only, no read return
        m0_req = 1; m0_wr = 1; m0_rd = 1; m0_addr = 21'h30;
        tick();
        chk("wr_ack0", m0_ack, 1);
        tick();
        m0_req = 0; m0_wr = 0; m0_rd = 0;
        chk("wr_fp_wr", fp_wr, 1);
        chk("wr_fp_rd", fp_rd, 0);
        tick();
        chk("wr_no_valid", m0_rd_valid, 0);
        tick();
        chk("wr_no_valid2", m0_rd_valid, 0);

        // both requesting from reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m0_req = 1; m0_wr = 1; m0_addr = 21'h100; m0_wr_data = 32'hA0;
        m1_req = 1; m1_wr = 1; m1_addr = 21'h200; m1_wr_data = 32'hB1;
        #1 chk("rr_bubble", {30'd0, m1_ack, m0_ack}, 0);
`ifdef FPRO_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("fp_ack1", m1_ack, 1);
            chk("fp_ack0", m0_ack, 0);
        end
        m1_req = 0;
        #1 chk("fp_ack1_drop", m1_ack, 0);
        tick();
        chk("fp_m0_served", m0_ack, 1);
        chk("fp_owner0", owner, 1);
        tick();
        m0_req = 0; m0_wr = 0; m1_wr = 0;
        tick();
`else
        for (int i = 0; i < 8; i++) begin
            tick();
            // last m0 beat is a read that must survive the handover
            if (i == 7) begin m0_wr = 0; m0_rd = 1; m0_addr = 21'h300; end
            #1;
            chk("rr_m0_ack0", m0_ack, 1);
            chk("rr_m0_ack1", m1_ack, 0);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 0) begin
                fp_rd_data = 32'hCAFEF00D;
                chk("ho_fp_rd", fp_rd, 1);
                chk("ho_fp_addr", fp_addr, 32'h300);
            end
            if (i == 1) begin
                chk("ho_valid0", m0_rd_valid, 1);
                chk("ho_valid1", m1_rd_valid, 0);
                chk("ho_data0", m0_rd_data, 32'hCAFEF00D);
                chk("ho_m1_wr", fp_wr, 1);
                chk("ho_m1_addr", fp_addr, 32'h200);
            end
            chk("rr_m1_ack1", m1_ack, 1);
            chk("rr_m1_ack0", m0_ack, 0);
        end
        tick();
        chk("rr_back_m0", m0_ack, 1);
        chk("rr_back_m1", m1_ack, 0);

        // reset one cycle after an accepted read
        tick();
        reset = 1'b1;
        chk("rs_fp_rd_pre", fp_rd, 1);
        tick();
        reset = 1'b0;
        m0_req = 0; m0_rd = 0; m1_req = 0; m1_wr = 0;
        chk("rs_valid0", m0_rd_valid, 0);
        chk("rs_fp_rd", fp_rd, 0);
        chk("rs_fp_wr", fp_wr, 0);
        chk("rs_fp_addr", fp_addr, 0);
        chk("rs_fp_data", fp_wr_data, 0);
        chk("rs_owner", owner, 0);
        tick();
        chk("rs_valid0_b", m0_rd_valid, 0);
        chk("rs_valid1_b", m1_rd_valid, 0);
`endif

        // m1 read is tagged to m1 only
        m1_req = 1; m1_rd = 1; m1_video_cs = 1; m1_addr = 21'h40; fp_rd_data = 32'h55AA;
        tick();
        chk("m1r_ack1", m1_ack, 1);
        chk("m1r_owner", owner, 2);
        tick();
        m1_req = 0; m1_rd = 0; m1_video_cs = 0;
        chk("m1r_fp_rd", fp_rd, 1);
        chk("m1r_fp_video", fp_video_cs, 1);
        chk("m1r_fp_addr", fp_addr, 32'h40);
        tick();
        chk("m1r_valid1", m1_rd_valid, 1);
        chk("m1r_valid0", m0_rd_valid, 0);
        chk("m1r_data1", m1_rd_data, 32'h55AA);
        tick();
        chk("m1r_valid1_off", m1_rd_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
